pipe_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder that generalises the single-bit full adder to WIDTH bits. The carry chain is split across STAGES register stages, so WIDTH can grow without lengthening the critical path. A valid/ready handshake sits on both sides, and the pipeline stalls on back-pressure without dropping or duplicating results. It is the datapath adder for the arithmetic blocks that follow in the combinational-to-sequential series.

---
 rtl/pipe_adder_pkg.sv | 21 ++
 rtl/pipe_adder_if.sv | 42 ++++
 rtl/pipe_adder_add_slice.sv | 34 +++
 rtl/pipe_adder.sv | 128 ++++++++++++
 tb/tb_pipe_adder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants, geometry helpers and full-adder cell for pipe_adder
package pipe_adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The carry chain is cut into equal slices, so the width must divide evenly.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder; sub exists only with PIPE_ADDER_SUB_EN
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

`ifdef PIPE_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
`endif

endinterface

// File: rtl/pipe_adder_add_slice.sv
// rtl/pipe_adder_add_slice.sv - combinational SLICE-bit ripple adder built from full-adder cells
module add_slice
  import pipe_adder_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] carry;

  always_comb begin : ripple
    logic [1:0] fa;
    fa       = '0;
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      fa         = full_add(a[i], b[i], carry[i]);
      sum[i]     = fa[0];
      carry[i+1] = fa[1];
    end
  end

  assign cout  = carry[SLICE];
  // Carry into the top bit, needed by the last stage for signed overflow.
  assign c_msb = carry[SLICE-1];

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder with valid/ready stall; PIPE_ADDER_SUB_EN adds subtract
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_adder_if.slave  bus
);

  localparam int SLICE = slice_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic en;
  logic last_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_src;
    logic             c_src;
    logic             s_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] sum_src;
    logic [WIDTH-1:0] sum_nxt;
    logic [SLICE-1:0] b_eff;
    logic [SLICE-1:0] s_slice;
    logic             co;
    logic             cmsb;

    logic             v_q;
    logic             c_q;
    logic             s_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;

    if (k == 0) begin : g_head
      assign v_src   = bus.in_valid;
      assign a_src   = bus.a;
      assign b_src   = bus.b;
      assign sum_src = '0;
`ifdef PIPE_ADDER_SUB_EN
      assign s_src   = bus.sub;
      assign c_src   = bus.cin | bus.sub;
`else
      assign s_src   = 1'b0;
      assign c_src   = bus.cin;
`endif
    end else begin : g_body
      // Operands travel whole; each stage consumes its own slice of the skewed copy.
      assign v_src   = g_stage[k-1].v_q;
      assign a_src   = g_stage[k-1].a_q;
      assign b_src   = g_stage[k-1].b_q;
      assign sum_src = g_stage[k-1].sum_q;
      assign s_src   = g_stage[k-1].s_q;
      assign c_src   = g_stage[k-1].c_q;
    end

    assign b_eff = b_src[k*SLICE +: SLICE] ^ {SLICE{s_src}};

    add_slice #(.SLICE(SLICE)) u_slice (
      .a     (a_src[k*SLICE +: SLICE]),
      .b     (b_eff),
      .cin   (c_src),
      .sum   (s_slice),
      .cout  (co),
      .c_msb (cmsb)
    );

    always_comb begin
      sum_nxt                     = sum_src;
      sum_nxt[k*SLICE +: SLICE]   = s_slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_src;
        c_q   <= co;
        s_q   <= s_src;
        a_q   <= a_src;
        b_q   <= b_src;
        sum_q <= sum_nxt;
      end
    end

    if (k == LAST) begin : g_tail
      logic ovf_q;
      logic unused_tail;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= co ^ cmsb;
        end
      end

      assign unused_tail = ^{a_q, b_q, s_q};
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = cmsb;
    end
  end

  // Every slot advances together; bubbles are kept rather than squeezed out.
  assign last_valid   = g_stage[LAST].v_q;
  assign en           = !last_valid || bus.out_ready;
  assign bus.in_ready = en;

  assign bus.out_valid = last_valid;
  assign bus.sum       = g_stage[LAST].sum_q;
  assign bus.cout      = g_stage[LAST].c_q;
  assign bus.overflow  = g_stage[LAST].g_tail.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder (vector table, scoreboard, stall/reset sequences)
module tb_pipe_adder;

  localparam int W = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W)) bus ();

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  int   total = 0;
  int   bad = 0;
  int   emitted = 0;
  res_t exp_q[$];
  logic got;
  res_t got_r;
  logic last_ov;
  logic last_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic; overflow = signed result out of 8-bit range.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    res_t        r;
    logic [7:0]  bn;
    int unsigned full;
    int          sa, sb, ci, ss;
    bn     = sub ? ~b : b;
    ci     = (cin || sub) ? 1 : 0;
    full   = 32'(a) + 32'(bn) + 32'(ci);
    r.sum  = full[7:0];
    r.cout = full[8];
    sa     = $signed(a);
    sb     = $signed(bn);
    ss     = sa + sb + ci;
    r.ovf  = (ss > 127) || (ss < -128);
    return r;
  endfunction

  task automatic cycle(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic si, input logic orv, output logic acc);
    res_t e;
    logic s_eff;
    @(negedge clk);
`ifdef PIPE_ADDER_SUB_EN
    s_eff   = si;
    bus.sub = si;
`else
    s_eff   = 1'b0 & si;
`endif
    bus.in_valid  = iv;
    bus.a         = av;
    bus.b         = bv;
    bus.cin       = ci;
    bus.out_ready = orv;
    #1;
    last_ov = bus.out_valid;
    last_ir = bus.in_ready;
    got     = 1'b0;
    if (bus.out_valid && orv) begin
      got        = 1'b1;
      got_r.sum  = bus.sum;
      got_r.cout = bus.cout;
      got_r.ovf  = bus.overflow;
      emitted++;
      check("sb_result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_sum", 32'(bus.sum), 32'(e.sum));
        check("sb_cout", 32'(bus.cout), 32'(e.cout));
        check("sb_overflow", 32'(bus.overflow), 32'(e.ovf));
      end
    end
    acc = iv && bus.in_ready;
    if (acc) exp_q.push_back(model(av, bv, ci, s_eff));
  endtask

  initial begin
    vec_t        vecs[$];
    logic        acc;
    int          wait_n;
    int          sent;
    logic [13:0] ov_trace;
    logic [13:0] ov_want;
    int          ov_count;

    vecs.push_back('{a:8'h0F, b:8'h01, cin:1'b0, sub:1'b0, sum:8'h10, cout:1'b0, ovf:1'b0});
    vecs.push_back('{a:8'hFF, b:8'h01, cin:1'b0, sub:1'b0, sum:8'h00, cout:1'b1, ovf:1'b0});
    vecs.push_back('{a:8'h7F, b:8'h01, cin:1'b0, sub:1'b0, sum:8'h80, cout:1'b0, ovf:1'b1});
    vecs.push_back('{a:8'h80, b:8'h80, cin:1'b0, sub:1'b0, sum:8'h00, cout:1'b1, ovf:1'b1});
    vecs.push_back('{a:8'h00, b:8'h00, cin:1'b1, sub:1'b0, sum:8'h01, cout:1'b0, ovf:1'b0});
    vecs.push_back('{a:8'hFF, b:8'hFF, cin:1'b1, sub:1'b0, sum:8'hFF, cout:1'b1, ovf:1'b0});
    vecs.push_back('{a:8'h3C, b:8'hC4, cin:1'b0, sub:1'b0, sum:8'h00, cout:1'b1, ovf:1'b0});
`ifdef PIPE_ADDER_SUB_EN
    vecs.push_back('{a:8'h05, b:8'h07, cin:1'b0, sub:1'b1, sum:8'hFE, cout:1'b0, ovf:1'b0});
    vecs.push_back('{a:8'h80, b:8'h01, cin:1'b0, sub:1'b1, sum:8'h7F, cout:1'b1, ovf:1'b1});
    vecs.push_back('{a:8'h10, b:8'h10, cin:1'b0, sub:1'b1, sum:8'h00, cout:1'b1, ovf:1'b0});
`endif

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif
    rst_n = 1'b0;
    #11;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_sum", 32'(bus.sum), 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;

    // Vector table: one operation at a time, latency measured in cycles.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1, acc);
      check($sformatf("vec%0d_accept", i), 32'(acc), 32'd1);
      wait_n = 0;
      do begin
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        wait_n++;
      end while (!got && wait_n < 10);
      check($sformatf("vec%0d_latency", i), 32'(wait_n), 32'(S));
      check($sformatf("vec%0d_sum", i), 32'(got_r.sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(got_r.cout), 32'(vecs[i].cout));
      check($sformatf("vec%0d_overflow", i), 32'(got_r.ovf), 32'(vecs[i].ovf));
    end

    // Streaming: 8 back-to-back operations, outputs expected in cycles 4..11.
    emitted = 0;
    for (int c = 0; c < 14; c++) begin
      cycle(c < 8, 8'(c), 8'(2 * c), c[0], 1'b0, 1'b1, acc);
      ov_trace[c] = last_ov;
      ov_want[c]  = (c >= 4) && (c < 12);
    end
    check("stream_out_valid_trace", 32'(ov_trace), 32'(ov_want));
    check("stream_count", 32'(emitted), 32'd8);

    // Back-pressure: out_ready low for cycles 5..7 while the pipe is full.
    emitted = 0;
    sent    = 0;
    for (int c = 0; c < 40 && emitted < 8; c++) begin
      cycle(sent < 8, 8'(sent * 3 + 200), 8'(sent * 5 + 1), sent[0], 1'b0, !(c >= 5 && c < 8), acc);
      if (acc) sent++;
      if (c >= 5 && c < 8) begin
        check($sformatf("bp_in_ready_c%0d", c), 32'(last_ir), 32'd0);
        check($sformatf("bp_out_valid_c%0d", c), 32'(last_ov), 32'd1);
        if (exp_q.size() != 0)
          check($sformatf("bp_sum_held_c%0d", c), 32'(bus.sum), 32'(exp_q[0].sum));
      end
      if (c == 8) check("bp_in_ready_resume", 32'(last_ir), 32'd1);
    end
    check("bp_delivered", 32'(emitted), 32'd8);
    check("bp_sent", 32'(sent), 32'd8);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two operations in flight.
    cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    ov_count = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      if (last_ov) ov_count++;
    end
    check("midrst_no_output", 32'(ov_count), 32'd0);

    // Random traffic with random back-pressure against the reference model.
    emitted = 0;
    sent    = 0;
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++)
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(emitted), 32'(sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
